// File: rtl/inst_fetch_bridge_pkg.sv
// Shared types and constants for the instruction fetch bridge.
// Holds bus widths, FSM encodings and the timeout counter sizing helper.
package inst_fetch_bridge_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS      = 32;

  localparam logic [31:0] IFB_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFB_IDLE  = 2'd0,
    IFB_REQ   = 2'd1,
    IFB_WAIT  = 2'd2,
    IFB_DRAIN = 2'd3
  } ifb_state_e;

  function automatic int tmo_cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/inst_fetch_bridge_if.sv
// Instruction memory read port: req/gnt address phase, rvalid data phase.
// The bridge drives it through the master modport.
interface inst_fetch_bridge_if
  import inst_fetch_bridge_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_BUS,
  parameter int DATA_W = INST_BUS
);

  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i
  );

endinterface

// File: rtl/inst_fetch_bridge_buffer.sv
// One-entry fetch buffer: tag/data/valid register with a
// combinational hit compare against the current fetch tag.
module inst_fetch_bridge_buffer #(
  parameter int TAG_W  = 30,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ce,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              hit,
  output logic [DATA_W-1:0] rd_data
);

  logic              buf_valid;
  logic [TAG_W-1:0]  buf_tag;
  logic [DATA_W-1:0] buf_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (flush) begin
      buf_valid <= 1'b0;
    end else if (wr_en) begin
      buf_valid <= 1'b1;
      buf_tag   <= wr_tag;
      buf_data  <= wr_data;
    end
  end

  assign hit = ce & buf_valid & (buf_tag == rd_tag) & ~flush;
  assign rd_data = buf_data;

endmodule

// File: rtl/inst_fetch_bridge.sv
// Fetch bridge between the core's ROM port and a req/gnt/rvalid memory.
// Optional IFB_TIMEOUT_EN adds a wait timeout with a sticky err_o.
module inst_fetch_bridge
  import inst_fetch_bridge_pkg::*;
#(
  parameter int ADDR_W         = INST_ADDR_BUS,
  parameter int DATA_W         = INST_BUS,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              stallreq_o,
  input  logic              flush_i,
`ifdef IFB_TIMEOUT_EN
  output logic              err_o,
`endif
  inst_fetch_bridge_if.master mem
);

  localparam int TW = ADDR_W - 2;

  ifb_state_e        state;
  logic [ADDR_W-1:0] req_addr;
  logic              hit;
  logic [DATA_W-1:0] buf_data;
  logic              start;
  logic              rv_fill;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              tmo;
  logic              unused_bits;

  assign unused_bits = ^{addr_i[1:0], req_addr[1:0]};

  inst_fetch_bridge_buffer #(
    .TAG_W (TW),
    .DATA_W(DATA_W)
  ) u_buf (
    .clk,
    .rst,
    .flush  (flush_i),
    .wr_en,
    .wr_tag (req_addr[ADDR_W-1:2]),
    .wr_data,
    .ce     (ce_i),
    .rd_tag (addr_i[ADDR_W-1:2]),
    .hit,
    .rd_data(buf_data)
  );

  assign inst_o     = hit ? buf_data : '0;
  assign stallreq_o = ce_i & ~hit;
  assign start      = ce_i & ~hit & ~flush_i;

  // Real data wins over a timeout landing in the same cycle
  assign rv_fill = (state == IFB_WAIT) & mem.mem_rvalid_i & ~flush_i;
  assign wr_en   = rv_fill | tmo;
  assign wr_data = rv_fill ? mem.mem_rdata_i : DATA_W'(IFB_NOP);

  assign mem.mem_req_o  = (state == IFB_REQ);
  assign mem.mem_addr_o = {req_addr[ADDR_W-1:2], 2'b00};

`ifdef IFB_TIMEOUT_EN
  localparam int CW = tmo_cnt_w(TIMEOUT_CYCLES);

  ifb_state_e    prev;
  logic [CW-1:0] cnt;
  logic [CW-1:0] age;
  logic          busy;

  // age restarts at zero on the first cycle of every state
  assign busy = (state == IFB_REQ) || (state == IFB_WAIT);
  assign age  = (state != prev) ? '0 : cnt;
  assign tmo  = busy & ~flush_i &
                (age == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev  <= IFB_IDLE;
      cnt   <= '0;
      err_o <= 1'b0;
    end else begin
      prev <= state;
      cnt  <= age + 1'b1;
      if (tmo) err_o <= 1'b1;
    end
  end
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IFB_IDLE;
      req_addr <= '0;
    end else begin
      unique case (state)
        IFB_IDLE: begin
          if (start) begin
            req_addr <= addr_i;
            state    <= IFB_REQ;
          end
        end
        IFB_REQ: begin
          if (flush_i || tmo)
            state <= mem.mem_gnt_i ? IFB_DRAIN : IFB_IDLE;
          else if (mem.mem_gnt_i)
            state <= IFB_WAIT;
        end
        IFB_WAIT: begin
          if (flush_i)
            state <= mem.mem_rvalid_i ? IFB_IDLE : IFB_DRAIN;
          else if (mem.mem_rvalid_i)
            state <= IFB_IDLE;
          else if (tmo)
            state <= IFB_DRAIN;
        end
        IFB_DRAIN: begin
          if (mem.mem_rvalid_i) state <= IFB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge with a latency-programmable
// memory responder and a queue of expected instructions.
module tb_inst_fetch_bridge;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        stall;
  logic        flush;
`ifdef IFB_TIMEOUT_EN
  logic        err;
`endif

  inst_fetch_bridge_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  inst_fetch_bridge #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce_i      (ce),
    .addr_i    (addr),
    .inst_o    (inst),
    .stallreq_o(stall),
    .flush_i   (flush),
`ifdef IFB_TIMEOUT_EN
    .err_o     (err),
`endif
    .mem       (mif.master)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];

  bit          gnt_en = 1'b1;
  int          rv_lat = 1;
  bit          pend;
  int          rv_cnt;
  logic [31:0] pend_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    case (w)
      32'h0000_0000: return 32'h3401_1100;
      32'h0000_0040: return 32'hDEAD_BEEF;
      default:       return 32'hA500_0000 | w;
    endcase
  endfunction

  // Memory model: gnt whenever allowed, rvalid rv_lat cycles later
  initial begin
    pend = 1'b0;
    rv_cnt = 0;
    pend_addr = '0;
    mif.mem_gnt_i = 1'b0;
    mif.mem_rvalid_i = 1'b0;
    mif.mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #2;
      mif.mem_rvalid_i = 1'b0;
      if (!rst) begin
        pend = 1'b0;
        mif.mem_gnt_i = 1'b0;
      end else begin
        if (pend) begin
          if (rv_cnt == 0) begin
            mif.mem_rvalid_i = 1'b1;
            mif.mem_rdata_i = mem_word(pend_addr);
            pend = 1'b0;
          end else begin
            rv_cnt--;
          end
        end
        mif.mem_gnt_i = mif.mem_req_o && gnt_en &&
                        !pend && !mif.mem_rvalid_i;
        if (mif.mem_gnt_i) begin
          pend = 1'b1;
          pend_addr = mif.mem_addr_o;
          rv_cnt = rv_lat - 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] a, input int exp_stall);
    int n;
    logic [31:0] e;
    n = 0;
    addr = a;
    ce = 1'b1;
    sb.push_back(mem_word(a));
    @(negedge clk);
    while (stall && n < 50) begin
      n++;
      tick();
      @(negedge clk);
    end
    e = sb.pop_front();
    chk("fetch_stall_done", 32'(stall), 32'd0);
    chk("fetch_inst", inst, e);
    if (exp_stall >= 0) chk("fetch_stall_cycles", 32'(n), 32'(exp_stall));
    tick();
  endtask

  initial begin
    int bad;
    bit sawc;
    logic [31:0] e;
    int n;
    rst = 1'b0;
    ce = 1'b0;
    addr = '0;
    flush = 1'b0;

    @(posedge clk);
    #1;
    chk("rst_inst", inst, 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(mif.mem_req_o), 32'd0);
    chk("rst_addr", mif.mem_addr_o, 32'h0);
`ifdef IFB_TIMEOUT_EN
    chk("rst_err", 32'(err), 32'd0);
`endif
    rst = 1'b1;

    // First miss: gnt immediate, rvalid one cycle later
    fetch(32'h0, 3);

    fetch(32'h4, 3);
    @(negedge clk);
    chk("hold_inst", inst, mem_word(32'h4));
    chk("hold_stall", 32'(stall), 32'd0);
    tick();
    fetch(32'h6, 0);
    @(negedge clk);
    chk("low_bits_noreq", 32'(mif.mem_req_o), 32'd0);
    tick();

    // PC moves from 0x8 to 0xC while the 0x8 fetch is in WAIT
    rv_lat = 3;
    addr = 32'h8;
    ce = 1'b1;
    tick();
    tick();
    addr = 32'hC;
    sb.push_back(mem_word(32'hC));
    bad = 0;
    sawc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst === mem_word(32'h8)) bad++;
      if (mif.mem_req_o && mif.mem_addr_o == 32'hC) sawc = 1'b1;
      if (!stall) break;
      tick();
    end
    e = sb.pop_front();
    chk("pc_change_inst", inst, e);
    chk("pc_change_wrong_tag", 32'(bad), 32'd0);
    chk("pc_change_req_c", 32'(sawc), 32'd1);
    tick();

    // Flush in WAIT: orphan rvalid arrives two cycles later
    addr = 32'h40;
    ce = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", 32'(stall), 32'd1);
    chk("flush_inst", inst, 32'h0);
    tick();
    flush = 1'b0;
    rv_lat = 1;
    @(negedge clk);
    chk("drain_noreq0", 32'(mif.mem_req_o), 32'd0);
    tick();
    @(negedge clk);
    chk("drain_noreq1", 32'(mif.mem_req_o), 32'd0);
    chk("drain_inst", inst, 32'h0);
    tick();
    fetch(32'h40, 3);

    // Flush coinciding with rvalid discards the data
    addr = 32'h50;
    ce = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fetch(32'h50, 3);

    // Flush in REQ without gnt withdraws the request
    gnt_en = 1'b0;
    addr = 32'h62;
    ce = 1'b1;
    tick();
    @(negedge clk);
    chk("req_up", 32'(mif.mem_req_o), 32'd1);
    chk("req_aligned", mif.mem_addr_o, 32'h60);
    tick();
    addr = 32'h70;
    @(negedge clk);
    chk("req_addr_stable", mif.mem_addr_o, 32'h60);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ce = 1'b0;
    @(negedge clk);
    chk("flush_withdraw", 32'(mif.mem_req_o), 32'd0);
    gnt_en = 1'b1;
    tick();
    fetch(32'h62, 3);

    // ce low gates outputs; flush invalidates a valid buffer
    ce = 1'b0;
    @(negedge clk);
    chk("ce_off_inst", inst, 32'h0);
    chk("ce_off_stall", 32'(stall), 32'd0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fetch(32'h60, 3);

`ifdef IFB_TIMEOUT_EN
    gnt_en = 1'b0;
    addr = 32'h80;
    ce = 1'b1;
    sb.push_back(32'h0);
    n = 0;
    @(negedge clk);
    while (stall && n < 30) begin
      n++;
      tick();
      @(negedge clk);
    end
    e = sb.pop_front();
    chk("tmo_cycles", 32'(n), 32'd9);
    chk("tmo_inst", inst, e);
    chk("tmo_stall", 32'(stall), 32'd0);
    chk("tmo_err", 32'(err), 32'd1);
    ce = 1'b0;
    gnt_en = 1'b1;
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("tmo_err_sticky", 32'(err), 32'd1);
    tick();
`else
    n = 0;
    e = '0;
`endif

    // Asynchronous reset mid-run
    ce = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst2_req", 32'(mif.mem_req_o), 32'd0);
    chk("rst2_addr", mif.mem_addr_o, 32'h0);
    chk("rst2_inst", inst, 32'h0);
    chk("rst2_stall", 32'(stall), 32'd0);
`ifdef IFB_TIMEOUT_EN
    chk("rst2_err", 32'(err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
